// File: rtl/fifo_pkg.sv
// Width helpers shared by the FIFO family.
// Counts span 0..depth; pointers span 0..depth-1 and are never narrower than one bit.
package fifo_pkg;

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int fifo_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-(MAX+1) pointer: wraps on an explicit compare so any depth works.
module fifo_wrap_ptr #(
   parameter int PTR_W = 3,
   parameter int MAX   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(MAX);

   logic [PTR_W-1:0] ptr_reg;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ptr_reg <= '0;
      end else if (inc) begin
         ptr_reg <= (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_sync_thr.sv
// Synchronous first-word-fall-through FIFO of arbitrary depth with programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow.
module fifo_sync_thr
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = fifo_cnt_w(FIFO_DEPTH),
   parameter int PTR_W      = fifo_ptr_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [CNT_W-1:0]      afull_thr,
   input  logic [CNT_W-1:0]      aempty_thr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CNT_W-1:0]      data_count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [CNT_W-1:0]      count_reg;
   logic                  overflow_reg;
   logic                  underflow_reg;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  flush;

   assign flush  = reset | clear;
   assign rd_acc = rd_en & ~empty;
   // At full a write only fits when the head leaves in the same cycle.
   assign wr_acc = wr_en & (~full | rd_acc);

   fifo_wrap_ptr #(.PTR_W(PTR_W), .MAX(FIFO_DEPTH - 1)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (wr_acc),
      .ptr   (wr_ptr)
   );

   fifo_wrap_ptr #(.PTR_W(PTR_W), .MAX(FIFO_DEPTH - 1)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (rd_acc),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_acc && !flush) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         overflow_reg  <= overflow_reg | (wr_en & ~wr_acc);
         underflow_reg <= underflow_reg | (rd_en & ~rd_acc);
      end
   end

   assign data_count   = count_reg;
   assign empty        = (count_reg == '0);
   assign full         = (count_reg == DEPTH_CNT);
   assign almost_full  = (count_reg >= afull_thr);
   assign almost_empty = (count_reg <= aempty_thr);
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;
   // Gate the head so a consumer never sees a stale word from a drained FIFO.
   assign data_out     = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Randomised and directed bench for fifo_sync_thr against a queue-based model.
module tb_fifo_sync_thr;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset, clear, wr_en, rd_en;
   logic [DW-1:0] data_in;
   logic [CW-1:0] afull_thr, aempty_thr;
   logic [DW-1:0] data_out;
   logic [CW-1:0] data_count;
   logic          empty, full, almost_empty, almost_full, overflow, underflow;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf;

   fifo_sync_thr #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .afull_thr    (afull_thr),
      .aempty_thr   (aempty_thr),
      .data_out     (data_out),
      .data_count   (data_count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model update from the inputs present at the edge and the pre-edge queue.
   task automatic model_edge();
      bit ra, wa;
      if (reset || clear) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         ra = rd_en && (q.size() > 0);
         wa = wr_en && ((q.size() < DEPTH) || ra);
         if (ra) void'(q.pop_front());
         if (wa) q.push_back(data_in);
         if (wr_en && !wa) m_ovf = 1;
         if (rd_en && !ra) m_unf = 1;
      end
   endtask

   // Drive one cycle; called at posedge+1, returns at the next posedge+1.
   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c = 0);
      wr_en = w; data_in = d; rd_en = r; clear = c;
      @(posedge clk);
      model_edge();
      #1;
      wr_en = 0; rd_en = 0; clear = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         expect_eq("count", 32'(data_count), 32'(q.size()));
         expect_eq("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0]) : 32'h0);
         expect_eq("empty", 32'(empty), 32'(q.size() == 0));
         expect_eq("full", 32'(full), 32'(q.size() == DEPTH));
         expect_eq("almost_full", 32'(almost_full), 32'(q.size() >= int'(afull_thr)));
         expect_eq("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(aempty_thr)));
         expect_eq("overflow", 32'(overflow), 32'(m_ovf));
         expect_eq("underflow", 32'(underflow), 32'(m_unf));
      end
   end

   initial begin
      reset = 1; clear = 0; wr_en = 0; rd_en = 0; data_in = 0;
      afull_thr = 3'd4; aempty_thr = 3'd1;
      repeat (2) @(posedge clk);
      model_edge();
      #1;
      reset = 0;
      chk_en = 1;
      expect_eq("rst_empty", 32'(empty), 32'h1);
      expect_eq("rst_count", 32'(data_count), 32'h0);
      expect_eq("rst_data_out", 32'(data_out), 32'h0);

      // Fill then drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 8'h11 + 8'(i), 0);
         $display("t1 wr %0h count=%0d af=%0b", 8'h11 + i, data_count, almost_full);
         expect_eq("t1_af", 32'(almost_full), 32'(i >= 3));
      end
      expect_eq("t1_full", 32'(full), 32'h1);
      expect_eq("t1_count", 32'(data_count), 32'h5);
      for (int i = 0; i < DEPTH; i++) begin
         expect_eq("t1_rd", 32'(data_out), 32'h11 + 32'(i));
         $display("t1 rd %0h", data_out);
         cyc(0, 0, 1);
      end
      expect_eq("t1_empty", 32'(empty), 32'h1);
      expect_eq("t1_dout0", 32'(data_out), 32'h0);

      // Overflow at full, then pass-through write alongside a read.
      for (int i = 0; i < DEPTH; i++) cyc(1, 8'h21 + 8'(i), 0);
      cyc(1, 8'h99, 0);
      expect_eq("t2_ovf", 32'(overflow), 32'h1);
      expect_eq("t2_count", 32'(data_count), 32'h5);
      cyc(1, 8'h99, 1);
      expect_eq("t2_pass_count", 32'(data_count), 32'h5);
      for (int i = 0; i < DEPTH; i++) begin
         expect_eq("t2_rd", 32'(data_out), (i < 4) ? 32'h22 + 32'(i) : 32'h99);
         $display("t2 rd %0h", data_out);
         cyc(0, 0, 1);
      end
      expect_eq("t2_empty", 32'(empty), 32'h1);
      cyc(0, 0, 0, 1);

      // Simultaneous write+read at empty.
      cyc(1, 8'h42, 1);
      $display("t3 count=%0d unf=%0b dout=%0h", data_count, underflow, data_out);
      expect_eq("t3_unf", 32'(underflow), 32'h1);
      expect_eq("t3_count", 32'(data_count), 32'h1);
      expect_eq("t3_dout", 32'(data_out), 32'h42);
      cyc(0, 0, 0, 1);

      // Pointer wrap.
      for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, 8'h50 + 8'(i), 0);
      expect_eq("t4_full", 32'(full), 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         expect_eq("t4_rd", 32'(data_out), 32'h50 + 32'(i));
         $display("t4 rd %0h", data_out);
         cyc(0, 0, 1);
      end

      // Clear drops the concurrent write.
      for (int i = 0; i < 3; i++) cyc(1, 8'h60 + 8'(i), 0);
      cyc(1, 8'h77, 0, 1);
      expect_eq("t5_count", 32'(data_count), 32'h0);
      expect_eq("t5_empty", 32'(empty), 32'h1);
      expect_eq("t5_ovf", 32'(overflow), 32'h0);

      // Threshold sweep.
      cyc(1, 8'h01, 0);
      cyc(1, 8'h02, 0);
      afull_thr = 3'd2;
      #1;
      expect_eq("t6_af", 32'(almost_full), 32'h1);
      aempty_thr = 3'd6;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 8'h03 + 8'(i), 0);
         expect_eq("t6_ae", 32'(almost_empty), 32'h1);
      end
      expect_eq("t6_full", 32'(full), 32'h1);
      cyc(0, 0, 0, 1);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            afull_thr  = 3'($urandom_range(0, 7));
            aempty_thr = 3'($urandom_range(0, 7));
         end
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0);
         $display("rnd %0d count=%0d dout=%0h ovf=%0b unf=%0b",
                  n, data_count, data_out, overflow, underflow);
      end

      @(negedge clk);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
